// File: rtl/btn_pkg.sv
// Shared types and default timing for the button conditioner.
package btn_pkg;

    // Per-channel hold state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } btn_state_e;

    // Default timing at 25 MHz: 10 ms debounce, 1 s long press, 200 ms repeat
    localparam int unsigned CNT_MAX_DEF  = 250_000;
    localparam int unsigned LONG_MAX_DEF = 25_000_000;
    localparam int unsigned REP_MAX_DEF  = 5_000_000;

    // Per-channel output bundle
    typedef struct packed {
        logic level;
        logic press;
        logic release_pulse;
        logic long_press;
        logic repeat_pulse;
    } btn_evt_t;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debouncer and press/hold/repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REP_MAX    = REP_MAX_DEF,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     raw,
    output btn_evt_t evt
);

    localparam int unsigned CNT_W  = $clog2(CNT_MAX + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_MAX + 1);
    localparam int unsigned REP_W  = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MAX);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_MAX - 1);
    localparam logic              RAW_IDLE  = ACTIVE_LOW;

    logic [1:0]        sync_q;
    logic              pressed_c;
    logic              level_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              flip_c;
    logic              rise_c;
    logic              fall_c;

    btn_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    // Two-flop synchroniser, parked at the not-pressed raw level in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{RAW_IDLE}};
        else     sync_q <= {sync_q[0], raw};
    end

    assign pressed_c = sync_q[1] ^ RAW_IDLE;

    // Level flips on the edge that completes CNT_MAX consecutive mismatches
    assign flip_c = (pressed_c != level_q) && (cnt_q == CNT_LAST);
    assign rise_c = flip_c && !level_q;
    assign fall_c = flip_c &&  level_q;

    // Debounce counter and debounced level; counter tops out at CNT_LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            if ((pressed_c == level_q) || flip_c) cnt_q <= '0;
            else                                  cnt_q <= cnt_q + CNT_W'(1);
            if (flip_c) level_q <= ~level_q;
        end
    end

    // Hold FSM next state; pulses align with the edge that changes level
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_HELD: begin
                if (fall_c) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    rep_d   = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                // hold_q stays at LONG_MAX here so it can never re-enter HELD
                if (fall_c) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                    rep_d     = '0;
                end else if (REPEAT_EN) begin
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
                rep_d   = '0;
            end
        endcase
    end

    // FSM state, counters and registered pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign evt = '{level:         level_q,
                   press:         press_q,
                   release_pulse: release_q,
                   long_press:    long_q,
                   repeat_pulse:  repeat_q};

endmodule

// File: rtl/btn_conditioner.sv
// N_CH independent button conditioners. "release" and "repeat" are reserved
// words, so those outputs carry a _pulse suffix.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEF,
    parameter int unsigned REP_MAX    = REP_MAX_DEF,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_pulse
);

    // One self-contained channel per button
    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        btn_evt_t evt;

        btn_channel #(
            .CNT_MAX    (CNT_MAX),
            .LONG_MAX   (LONG_MAX),
            .REP_MAX    (REP_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .REPEAT_EN  (REPEAT_EN)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (in_raw[i]),
            .evt (evt)
        );

        assign level[i]         = evt.level;
        assign press[i]         = evt.press;
        assign release_pulse[i] = evt.release_pulse;
        assign long_press[i]    = evt.long_press;
        assign repeat_pulse[i]  = evt.repeat_pulse;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: two DUTs (repeat on / off) against an event-time model.
module tb_btn_conditioner;

    localparam int N_CH     = 2;
    localparam int CNT_MAX  = 4;
    localparam int LONG_MAX = 10;
    localparam int REP_MAX  = 3;

    typedef struct packed {
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] press;
        logic [N_CH-1:0] rel;
        logic [N_CH-1:0] lng;
        logic [N_CH-1:0] rpt;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] in_raw = '1;

    logic [N_CH-1:0] level_a, press_a, rel_a, long_a, rpt_a;
    logic [N_CH-1:0] level_b, press_b, rel_b, long_b, rpt_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: raw samples in flight, mismatch run, level, press time
    bit   smp_old[N_CH];
    bit   smp_new[N_CH];
    int   run[N_CH];
    bit   lvl[N_CH];
    int   t_press[N_CH];
    int   t_now;

    logic [N_CH-1:0] rnd_raw;
    int              dur[N_CH];

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_CH(N_CH), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1'b1),
        .LONG_MAX(LONG_MAX), .REP_MAX(REP_MAX), .REPEAT_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .in_raw(in_raw),
        .level(level_a), .press(press_a), .release_pulse(rel_a),
        .long_press(long_a), .repeat_pulse(rpt_a)
    );

    btn_conditioner #(
        .N_CH(N_CH), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1'b1),
        .LONG_MAX(LONG_MAX), .REP_MAX(REP_MAX), .REPEAT_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .in_raw(in_raw),
        .level(level_b), .press(press_b), .release_pulse(rel_b),
        .long_press(long_b), .repeat_pulse(rpt_b)
    );

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            smp_old[c] = 1'b0;
            smp_new[c] = 1'b0;
            run[c]     = 0;
            lvl[c]     = 1'b0;
            t_press[c] = 0;
        end
    endfunction

    // One clock edge of the reference: pressed value arrives two edges late,
    // level flips after CNT_MAX mismatching edges, events are timed from press.
    function automatic obs_t model_step(input logic [N_CH-1:0] raw);
        obs_t o = '0;
        t_now++;
        for (int c = 0; c < N_CH; c++) begin
            bit s = smp_old[c];
            smp_old[c] = smp_new[c];
            smp_new[c] = ~raw[c];
            if (s != lvl[c]) begin
                run[c]++;
                if (run[c] == CNT_MAX) begin
                    lvl[c] = s;
                    run[c] = 0;
                    if (s) begin
                        o.press[c] = 1'b1;
                        t_press[c] = t_now;
                    end else begin
                        o.rel[c] = 1'b1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            o.level[c] = lvl[c];
            if (lvl[c] && !o.press[c]) begin
                int d = t_now - t_press[c];
                if (d == LONG_MAX)
                    o.lng[c] = 1'b1;
                else if (d > LONG_MAX && ((d - LONG_MAX) % REP_MAX) == 0)
                    o.rpt[c] = 1'b1;
            end
        end
        return o;
    endfunction

    // Advance one clock: record expectation for the edge, then drive next inputs
    task automatic cycle(input logic [N_CH-1:0] raw_nxt, input logic rst_nxt);
        exp_t e;
        @(posedge clk);
        #1;
        e = '0;
        if (rst_nxt) begin
            model_reset();
        end else if (!rst) begin
            e.a = model_step(in_raw);
            e.b = e.a;
            e.b.rpt = '0;
        end
        exp_q.push_back(e);
        rst    = rst_nxt;
        in_raw = raw_nxt;
    endtask

    task automatic hold(input logic [N_CH-1:0] raw, input int n);
        for (int k = 0; k < n; k++) cycle(raw, 1'b0);
    endtask

    // Monitor: compare both DUTs against the oldest expectation
    initial begin : monitor
        exp_t e;
        obs_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {level_a, press_a, rel_a, long_a, rpt_a};
                checks++;
                if (got !== e.a) begin
                    errors++;
                    $display("FAIL rep_on t=%0t lvl/prs/rel/lng/rpt got %b exp %b",
                             $time, got, e.a);
                end
                got = {level_b, press_b, rel_b, long_b, rpt_b};
                checks++;
                if (got !== e.b) begin
                    errors++;
                    $display("FAIL rep_off t=%0t lvl/prs/rel/lng/rpt got %b exp %b",
                             $time, got, e.b);
                end
            end
        end
    end

    initial begin : stimulus
        t_now = 0;
        model_reset();

        // Reset state
        repeat (3) cycle('1, 1'b1);
        cycle('1, 1'b0);
        hold('1, 4);

        // Clean press on ch0, hold into LONG with repeats, release on a repeat slot
        cycle(2'b10, 1'b0);
        hold(2'b10, 27);
        cycle(2'b11, 1'b0);
        hold('1, 10);

        // Three-cycle glitch
        hold(2'b10, 3);
        hold('1, 10);

        // Reset for two cycles while ch0 is in LONG, raw stays pressed
        hold(2'b10, 20);
        cycle(2'b10, 1'b1);
        cycle(2'b10, 1'b1);
        cycle(2'b10, 1'b0);
        hold(2'b10, 14);
        hold('1, 10);

        // Both channels pressed together
        hold(2'b00, 24);
        hold('1, 10);

        // Random segments of 1..30 cycles per channel with occasional reset
        rnd_raw = '1;
        for (int c = 0; c < N_CH; c++) dur[c] = $urandom_range(1, 30);
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (dur[c] == 0) begin
                    rnd_raw[c] = ~rnd_raw[c];
                    dur[c] = $urandom_range(1, 30);
                end
                dur[c]--;
            end
            if ($urandom_range(0, 249) == 0) begin
                cycle(rnd_raw, 1'b1);
                cycle(rnd_raw, 1'b1);
            end else begin
                cycle(rnd_raw, 1'b0);
            end
        end
        hold('1, 12);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter CNT_MAX, default 250_000: consecutive stable cycles required before the debounced level changes (10 ms at 25 MHz), at least 1.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, a raw 0 means pressed; when 0, a raw 1 means pressed.
REQ-004 Parameter LONG_MAX, default 25_000_000: held cycles, counted from the press pulse, before the long-press pulse (1 s); must exceed 1.
REQ-005 Parameter REP_MAX, default 5_000_000: auto-repeat period in cycles (200 ms), at least 1.
REQ-006 Parameter REPEAT_EN, default 1: when 0, no repeat pulses are ever generated.
REQ-007 Port clk, input, 1: single clock for all logic (clk_pix in the display design).
REQ-008 Port rst, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-009 Port in_raw, input, N_CH: raw asynchronous button pins, polarity set by ACTIVE_LOW.
REQ-010 Port level, output, N_CH: debounced state, always active-high (1 = pressed).
REQ-011 Port press, output, N_CH: one-cycle pulse when level rises.
REQ-012 Port release, output, N_CH: one-cycle pulse when level falls.
REQ-013 Port long_press, output, N_CH: one-cycle pulse when the hold reaches LONG_MAX.
REQ-014 Port repeat, output, N_CH: one-cycle pulse every REP_MAX cycles after long_press while held.

Function
REQ-015 Each channel shall be fully independent; no output bit shall depend on another channel's input.
REQ-016 Each in_raw bit shall pass through a 2-flop synchroniser, then be normalised to active-high.
REQ-017 Debounce counter: cleared in any cycle where the synchronised value equals level; otherwise incremented.
REQ-018 level shall toggle on the edge that completes CNT_MAX consecutive mismatch cycles; the counter clears on that edge.
REQ-019 Latency from a clean raw transition to the level change shall be exactly CNT_MAX+2 cycles.
REQ-020 A glitch shorter than CNT_MAX cycles shall never change level or emit any pulse.
REQ-021 Counter width shall be $clog2(CNT_MAX+1); the counter shall never wrap.
REQ-022 press, release, long_press and repeat shall be registered and asserted in the first cycle the new level is visible (press, release) or the qualifying cycle (long_press, repeat).
REQ-023 Per-channel FSM states: IDLE (level 0), HELD (level 1, before long press), LONG (level 1, after long press).
REQ-024 Transition IDLE->HELD on the level rise, with press.
REQ-025 Transition HELD->IDLE or LONG->IDLE on the level fall, with release; a pending long_press or repeat in that same cycle shall be suppressed.
REQ-026 Transition HELD->LONG when the hold count reaches LONG_MAX.
REQ-027 long_press shall fire exactly once per hold, LONG_MAX cycles after press, and only if level is still 1 in that cycle.
REQ-028 In LONG with REPEAT_EN=1, repeat shall fire at press+LONG_MAX+k*REP_MAX for k>=1, indefinitely; the repeat counter shall wrap to 0 at each pulse.
REQ-029 The hold counter shall saturate in LONG; it shall never wrap back into HELD.
REQ-030 At most one of press, release or long_press shall be high per channel per cycle.

Reset
REQ-031 rst asserted shall immediately force: synchronisers to the not-pressed raw value, all counters 0, FSM IDLE, all outputs 0.
REQ-032 Reset mid-hold shall emit no release pulse, either during reset or after it deasserts.
REQ-033 If in_raw shows pressed after rst deasserts, press shall occur exactly CNT_MAX+2 cycles later.

Structure
REQ-034 A shared package btn_pkg shall hold the FSM state encoding and the default timing constants (CNT_MAX, LONG_MAX, REP_MAX at 25 MHz).
REQ-035 One sub-module, btn_channel, shall implement a single channel; the top shall instantiate N_CH copies by generate.

Verification
(Bench parameters: CNT_MAX=4, LONG_MAX=10, REP_MAX=3, N_CH=2, ACTIVE_LOW=1.)
REQ-036 in_raw[0] 1->0 clean at cycle 0 -> level[0]=1 and press[0]=1 at cycle 6; channel 1 outputs all 0.
REQ-037 in_raw[0] low for 3 cycles, then high -> level, press and release all stay 0.
REQ-038 Hold channel 0 for 25 cycles after press -> long_press at press+10, repeat at +13, +16, +19, +22.
REQ-039 Release so level falls in the same cycle a repeat is due -> release=1, repeat=0, FSM IDLE.
REQ-040 rst pulsed 2 cycles while channel 0 is in LONG, raw held low -> all outputs 0 and no release; press reappears 6 cycles after rst deasserts.
REQ-041 Run REPEAT_EN=0 with both channels pressed simultaneously -> independent press and long_press pulses, no repeat pulses.
